// File: rtl/seven_seg_scan_pkg.sv
// ============================================================================
// Module  : seven_seg_scan_pkg
// Brief   : Shared segment codes and sizing constants for the 4-digit scanner.
// Revision: 1.0
// ============================================================================
`default_nettype none

package seven_seg_scan_pkg;

    localparam int c_REFRESH_DIV_DEF = 100000;
    localparam int c_IDX_W           = 2;

    // Active-low, bit order g,f,e,d,c,b,a
    localparam logic [6:0] c_SEG_0     = 7'h40;
    localparam logic [6:0] c_SEG_1     = 7'h79;
    localparam logic [6:0] c_SEG_2     = 7'h24;
    localparam logic [6:0] c_SEG_3     = 7'h30;
    localparam logic [6:0] c_SEG_4     = 7'h19;
    localparam logic [6:0] c_SEG_5     = 7'h12;
    localparam logic [6:0] c_SEG_6     = 7'h02;
    localparam logic [6:0] c_SEG_7     = 7'h78;
    localparam logic [6:0] c_SEG_8     = 7'h00;
    localparam logic [6:0] c_SEG_9     = 7'h10;
    localparam logic [6:0] c_SEG_DASH  = 7'h3F;
    localparam logic [6:0] c_SEG_BLANK = 7'h7F;

endpackage

`default_nettype wire

// File: rtl/seven_seg_scan_bcd_to_7seg.sv
// ============================================================================
// Module  : bcd_to_7seg
// Brief   : Combinational BCD to active-low 7-segment decode; 10..15 show a dash.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bcd_to_7seg
    import seven_seg_scan_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = c_SEG_DASH;
        case (code_i)
            4'd0:    seg_o = c_SEG_0;
            4'd1:    seg_o = c_SEG_1;
            4'd2:    seg_o = c_SEG_2;
            4'd3:    seg_o = c_SEG_3;
            4'd4:    seg_o = c_SEG_4;
            4'd5:    seg_o = c_SEG_5;
            4'd6:    seg_o = c_SEG_6;
            4'd7:    seg_o = c_SEG_7;
            4'd8:    seg_o = c_SEG_8;
            4'd9:    seg_o = c_SEG_9;
            default: seg_o = c_SEG_DASH;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/seven_seg_scan.sv
// ============================================================================
// Module  : seven_seg_scan
// Brief   : Time-multiplexed 4-digit 7-segment driver with leading-zero blanking.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seven_seg_scan
    import seven_seg_scan_pkg::*;
#(
    parameter int REFRESH_DIV = c_REFRESH_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] thos,
    input  logic [3:0] hund,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    input  logic       enable,
    input  logic       blank_lz,
    input  logic [3:0] dp_en,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int PW = $clog2(REFRESH_DIV);

    logic [PW-1:0]        cnt_q;
    logic [c_IDX_W-1:0]   idx_q;
    logic [3:0][3:0]      snap_q;
    logic [3:0]           an_q,  an_d;
    logic [6:0]           seg_q, seg_d;
    logic                 dp_q,  dp_d;
    logic                 tick;
    logic                 lz;
    logic [6:0]           dec_seg;

    assign tick = (cnt_q == PW'(REFRESH_DIV - 1));

    bcd_to_7seg u_dec (
        .code_i (snap_q[idx_q]),
        .seg_o  (dec_seg)
    );

    // A digit is a leading zero when it and every more-significant digit are 0.
    always_comb begin
        lz = 1'b0;
        case (idx_q)
            2'd3:    lz = (snap_q[3] == 4'd0);
            2'd2:    lz = (snap_q[3] == 4'd0) && (snap_q[2] == 4'd0);
            2'd1:    lz = (snap_q[3] == 4'd0) && (snap_q[2] == 4'd0) && (snap_q[1] == 4'd0);
            default: lz = 1'b0;
        endcase
    end

    always_comb begin
        an_d  = 4'hF;
        seg_d = c_SEG_BLANK;
        dp_d  = 1'b1;
        if (enable) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = (blank_lz && lz) ? c_SEG_BLANK : dec_seg;
            dp_d  = ~dp_en[idx_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            snap_q <= '0;
            an_q   <= 4'hF;
            seg_q  <= c_SEG_BLANK;
            dp_q   <= 1'b1;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
            if (tick) begin
                cnt_q <= '0;
                idx_q <= idx_q + c_IDX_W'(1);
                if (idx_q == 2'd3) begin
                    snap_q <= {thos, hund, tens, ones};
                end
            end else begin
                cnt_q <= cnt_q + PW'(1);
            end
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_scan.sv
// ============================================================================
// Module  : tb_seven_seg_scan
// Brief   : Randomised self-checking bench against a cycle-count reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seven_seg_scan;

    localparam int c_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] thos = 4'd0, hund = 4'd0, tens = 4'd0, ones = 4'd0;
    logic       enable = 1'b1;
    logic       blank_lz = 1'b0;
    logic [3:0] dp_en = 4'd0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_cmp = 0;
    int n_err = 0;

    seven_seg_scan #(.REFRESH_DIV(c_DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .thos     (thos),
        .hund     (hund),
        .tens     (tens),
        .ones     (ones),
        .enable   (enable),
        .blank_lz (blank_lz),
        .dp_en    (dp_en),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    // Reference model: slot number follows from elapsed clock edges alone.
    logic [6:0] c_SEG_TBL [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    int         m_cyc;
    logic [3:0] m_digit [4];
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    int         m_idx;

    assign m_idx = (m_cyc / c_DIV) % 4;

    function automatic logic ref_blank(int d);
        if (!blank_lz || d == 0) return 1'b0;
        for (int j = d; j < 4; j++)
            if (m_digit[j] != 4'd0) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc <= 0;
            for (int k = 0; k < 4; k++) m_digit[k] <= 4'd0;
            e_an  <= 4'hF;
            e_seg <= 7'h7F;
            e_dp  <= 1'b1;
        end else begin
            e_an  <= enable ? (4'hF ^ 4'(1 << m_idx)) : 4'hF;
            e_seg <= (!enable || ref_blank(m_idx)) ? 7'h7F : c_SEG_TBL[m_digit[m_idx]];
            e_dp  <= !(enable && dp_en[m_idx]);
            if (m_cyc % (4 * c_DIV) == 4 * c_DIV - 1) begin
                m_digit[0] <= ones;
                m_digit[1] <= tens;
                m_digit[2] <= hund;
                m_digit[3] <= thos;
            end
            m_cyc <= m_cyc + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("an",  32'(an),  32'(e_an));
        check("seg", 32'(seg), 32'(e_seg));
        check("dp",  32'(dp),  32'(e_dp));
    end

    task automatic set_digits(input logic [3:0] t, input logic [3:0] h,
                              input logic [3:0] te, input logic [3:0] o);
        thos = t; hund = h; tens = te; ones = o;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [3:0] rnd_digit();
        return ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    endfunction

    initial begin
        wait_cycles(3);
        rst_n = 1'b1;

        // Fixed value patterns: plain, leading zeros, all zero, dash
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        wait_cycles(40);
        blank_lz = 1'b1;
        set_digits(4'd0, 4'd0, 4'd5, 4'd7);
        wait_cycles(40);
        set_digits(4'd0, 4'd0, 4'd0, 4'd0);
        wait_cycles(40);
        set_digits(4'd12, 4'd0, 4'd0, 4'd0);
        wait_cycles(40);

        // Mid-scan input change and an enable gap
        blank_lz = 1'b0;
        dp_en = 4'b0101;
        set_digits(4'd1, 4'd1, 4'd1, 4'd1);
        wait_cycles(20);
        set_digits(4'd2, 4'd2, 4'd2, 4'd2);
        wait_cycles(10);
        enable = 1'b0;
        wait_cycles(6);
        enable = 1'b1;
        wait_cycles(30);

        // Random traffic with live blank_lz/dp_en/enable changes
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0)
                set_digits(rnd_digit(), rnd_digit(), rnd_digit(), rnd_digit());
            if ($urandom_range(0, 9) == 0) blank_lz = 1'($urandom);
            if ($urandom_range(0, 9) == 0) dp_en = 4'($urandom);
            if ($urandom_range(0, 15) == 0) enable = ~enable;
            wait_cycles(1);
        end
        enable = 1'b1;

        // Asynchronous reset between edges while slot 1 shows a decimal point
        dp_en = 4'b0010;
        begin
            int budget = 64;
            while (!(m_idx == 1 && (m_cyc % c_DIV) == 2) && budget > 0) begin
                wait_cycles(1);
                budget--;
            end
            check("sync_idx1", 32'(budget > 0), 32'd1);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_an",  32'(an),  32'hF);
        check("arst_seg", 32'(seg), 32'h7F);
        check("arst_dp",  32'(dp),  32'd1);
        wait_cycles(2);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_an", 32'(an), 32'hE);
        wait_cycles(1);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 5) == 0)
                set_digits(rnd_digit(), rnd_digit(), rnd_digit(), rnd_digit());
            if ($urandom_range(0, 9) == 0) blank_lz = 1'($urandom);
            if ($urandom_range(0, 9) == 0) dp_en = 4'($urandom);
            wait_cycles(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
